// File: rtl/mult_err_monitor_pkg.sv
// Shared types and width derivations for the approximate-multiplier error monitor.
package mult_err_monitor_pkg;

  localparam int unsigned W_DEF     = 6;
  localparam int unsigned NSAMP_DEF = 4096;

  localparam int unsigned PW_DEF = 2 * W_DEF;
  localparam int unsigned CW_DEF = 2 * W_DEF + 1;
  localparam int unsigned SW_DEF = 4 * W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_err_monitor_abs_diff.sv
// Unsigned absolute difference |x - y| for PW-bit operands.
module abs_diff #(
  parameter int unsigned PW = 12
) (
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] y,
  output logic [PW-1:0] d
);

  assign d = (x >= y) ? (x - y) : (y - x);

endmodule

// File: rtl/mult_err_monitor.sv
// Measures error statistics of an approximate multiplier over a run of NSAMP samples.
// Handshake: a sample transfers on a cycle where in_valid and in_ready are both 1.
module mult_err_monitor
  import mult_err_monitor_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned NSAMP = NSAMP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [2*W-1:0]    c,
  output logic              busy,
  output logic              done,
  output logic [2*W:0]      sample_cnt,
  output logic [2*W:0]      err_cnt,
  output logic [4*W-1:0]    sum_ed,
  output logic [2*W-1:0]    max_ed,
  output logic [W-1:0]      max_a,
  output logic [W-1:0]      max_b,
  output state_e            dbg_state
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 2 * W + 1;
  localparam int unsigned SW = 4 * W;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSAMP - 1);

  // Asynchronous assertion, release synchronized to clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_e state_q;
  logic   busy_q;
  logic   done_q;

  logic accept;
  logic last_accept;
  logic clear;

  logic [CW-1:0] sample_cnt_q;
  logic [CW-1:0] err_cnt_q,  err_cnt_d;
  logic [SW-1:0] sum_ed_q,   sum_ed_d;
  logic [PW-1:0] max_ed_q,   max_ed_d;
  logic [W-1:0]  max_a_q,    max_a_d;
  logic [W-1:0]  max_b_q,    max_b_d;

  logic          s1_valid_q;
  logic [PW-1:0] s1_prod_q;
  logic [PW-1:0] s1_c_q;
  logic [W-1:0]  s1_a_q;
  logic [W-1:0]  s1_b_q;

  logic [PW-1:0] prod;
  logic [PW-1:0] ed;

  assign in_ready    = (state_q == ST_RUN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_cnt_q == LAST_CNT);
  assign clear       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign prod        = PW'(a) * PW'(b);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_accept) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The last sample leaves stage 1 one edge after DRAIN is entered.
          if (!s1_valid_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  abs_diff #(.PW(PW)) u_abs_diff (
    .x (s1_prod_q),
    .y (s1_c_q),
    .d (ed)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    sum_ed_d  = sum_ed_q;
    max_ed_d  = max_ed_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
    if (s1_valid_q) begin
      err_cnt_d = err_cnt_q + CW'(ed != '0);
      sum_ed_d  = sum_ed_q + SW'(ed);
      // Strict compare keeps the first operands on a tie.
      if (ed > max_ed_q) begin
        max_ed_d = ed;
        max_a_d  = s1_a_q;
        max_b_d  = s1_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s1_valid_q   <= 1'b0;
      s1_prod_q    <= '0;
      s1_c_q       <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      max_a_q      <= '0;
      max_b_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_prod_q <= prod;
        s1_c_q    <= c;
        s1_a_q    <= a;
        s1_b_q    <= b;
      end
      if (clear) begin
        sample_cnt_q <= '0;
        err_cnt_q    <= '0;
        sum_ed_q     <= '0;
        max_ed_q     <= '0;
        max_a_q      <= '0;
        max_b_q      <= '0;
      end else begin
        if (accept) sample_cnt_q <= sample_cnt_q + CW'(1);
        err_cnt_q <= err_cnt_d;
        sum_ed_q  <= sum_ed_d;
        max_ed_q  <= max_ed_d;
        max_a_q   <= max_a_d;
        max_b_q   <= max_b_d;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
  assign max_a      = max_a_q;
  assign max_b      = max_b_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Scoreboard bench: three monitors (NSAMP = 4096, 4, 2) share stimulus; results checked on done.
module tb_mult_err_monitor;
  import mult_err_monitor_pkg::*;

  localparam int W  = 6;
  localparam int PW = 12;
  localparam int CW = 13;
  localparam int SW = 24;

  typedef struct packed {
    logic [1:0]    id;
    logic [CW-1:0] sc;
    logic [CW-1:0] ec;
    logic [SW-1:0] sum;
    logic [PW-1:0] mx;
    logic [W-1:0]  ma;
    logic [W-1:0]  mb;
  } exp_t;

  exp_t exp_q[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic [W-1:0]  a, b;
  logic [PW-1:0] c;
  logic          start_v    [3];
  logic          in_ready_v [3];
  logic          busy_v     [3];
  logic          done_v     [3];
  logic [CW-1:0] sc_v       [3];
  logic [CW-1:0] ec_v       [3];
  logic [SW-1:0] sum_v      [3];
  logic [PW-1:0] mx_v       [3];
  logic [W-1:0]  ma_v       [3];
  logic [W-1:0]  mb_v       [3];
  state_e        st_v       [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit done_prev [3] = '{1'b0, 1'b0, 1'b0};
  bit sc_over = 1'b0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mult_err_monitor #(
      .W     (W),
      .NSAMP ((k == 0) ? 4096 : ((k == 1) ? 4 : 2))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[k]),
      .in_valid   (in_valid),
      .in_ready   (in_ready_v[k]),
      .a          (a),
      .b          (b),
      .c          (c),
      .busy       (busy_v[k]),
      .done       (done_v[k]),
      .sample_cnt (sc_v[k]),
      .err_cnt    (ec_v[k]),
      .sum_ed     (sum_v[k]),
      .max_ed     (mx_v[k]),
      .max_a      (ma_v[k]),
      .max_b      (mb_v[k]),
      .dbg_state  (st_v[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: a rising done pops the next expected result.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] && !done_prev[k]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: instance %0d raised done with no expected entry", k);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_id",    k,        e.id);
          chk("sample_cnt", sc_v[k],  e.sc);
          chk("err_cnt",    ec_v[k],  e.ec);
          chk("sum_ed",     sum_v[k], e.sum);
          chk("max_ed",     mx_v[k],  e.mx);
          chk("max_a",      ma_v[k],  e.ma);
          chk("max_b",      mb_v[k],  e.mb);
        end
      end
      done_prev[k] = done_v[k];
    end
    if (sc_v[0] > 13'd4096) sc_over = 1'b1;
  end

  task automatic push(input int k, input int sc, input int ec, input int sum,
                      input int mx, input int ma, input int mb);
    exp_t e;
    e.id  = k[1:0];
    e.sc  = sc[CW-1:0];
    e.ec  = ec[CW-1:0];
    e.sum = sum[SW-1:0];
    e.mx  = mx[PW-1:0];
    e.ma  = ma[W-1:0];
    e.mb  = mb[W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  task automatic send(input int k, input int av, input int bv, input int cv);
    int n;
    n = 0;
    a = av[W-1:0];
    b = bv[W-1:0];
    c = cv[PW-1:0];
    in_valid = 1'b1;
    while (!in_ready_v[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_v[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: instance %0d in_ready low for %0d cycles, required 1", k, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sweep(input bit gaps, input int count);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send(0, i / 64, i % 64, (i / 64) * (i % 64));
    end
  endtask

  task automatic wait_done(input int k, input int lat, input string name);
    int n;
    n = 0;
    while (!done_v[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, lat);
    @(negedge clk); #1;
  endtask

  task automatic chk_all_zero(input int k, input string tag);
    chk({tag, "_state"},    st_v[k],       ST_IDLE);
    chk({tag, "_busy"},     busy_v[k],     0);
    chk({tag, "_done"},     done_v[k],     0);
    chk({tag, "_in_ready"}, in_ready_v[k], 0);
    chk({tag, "_sc"},       sc_v[k],       0);
    chk({tag, "_ec"},       ec_v[k],       0);
    chk({tag, "_sum"},      sum_v[k],      0);
    chk({tag, "_mx"},       mx_v[k],       0);
    chk({tag, "_ma"},       ma_v[k],       0);
    chk({tag, "_mb"},       mb_v[k],       0);
  endtask

  initial begin
    in_valid = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero(0, "rst");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Exact multiplier, full sweep, in_valid held high.
    push(0, 4096, 0, 0, 0, 0, 0);
    pulse_start(0);
    chk("busy_run", busy_v[0], 1);
    sweep(1'b0, 4096);
    chk("busy_drain", busy_v[0], 1);
    wait_done(0, 2, "done_latency_exact");
    chk("busy_after_done", busy_v[0], 0);

    // Directed errors, with start pulses in RUN and DRAIN that must be ignored.
    push(1, 4, 3, 3975, 3969, 63, 63);
    pulse_start(1);
    send(1, 63, 63, 0);
    send(1, 2, 3, 6);
    pulse_start(1);
    chk("start_in_run_sc", sc_v[1], 2);
    chk("start_in_run_state", st_v[1], ST_RUN);
    send(1, 5, 5, 30);
    send(1, 1, 1, 0);
    chk("drain_state", st_v[1], ST_DRAIN);
    pulse_start(1);
    wait_done(1, 1, "done_after_drain_start");

    // Start in DONE clears results and runs again.
    pulse_start(1);
    chk("restart_state", st_v[1], ST_RUN);
    chk("restart_done", done_v[1], 0);
    chk("restart_sc", sc_v[1], 0);
    chk("restart_ec", ec_v[1], 0);
    chk("restart_sum", sum_v[1], 0);
    chk("restart_mx", mx_v[1], 0);
    push(1, 4, 3, 18, 9, 3, 3);
    send(1, 10, 10, 100);
    send(1, 7, 8, 60);
    send(1, 3, 3, 0);
    send(1, 0, 0, 5);
    wait_done(1, 2, "done_latency_run2");

    // Tie: first of two equal errors keeps its operands.
    push(2, 2, 2, 4, 2, 4, 4);
    pulse_start(2);
    send(2, 4, 4, 14);
    send(2, 2, 9, 16);
    wait_done(2, 2, "done_latency_tie");

    // Full sweep with random in_valid gaps.
    push(0, 4096, 0, 0, 0, 0, 0);
    pulse_start(0);
    sweep(1'b1, 4096);
    wait_done(0, 2, "done_latency_gaps");

    // Reset in the middle of a run.
    pulse_start(0);
    sweep(1'b0, 100);
    chk("pre_reset_sc", sc_v[0], 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero(0, "midrun_rst");
    chk("midrun_rst_inst1_done", done_v[1], 0);
    #5;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push(0, 4096, 0, 0, 0, 0, 0);
    pulse_start(0);
    sweep(1'b0, 4096);
    wait_done(0, 2, "done_latency_after_reset");

    chk("sample_cnt_bound", sc_over, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
